// File: rtl/decode_hazard_controller_if.sv
// Decode-stage control bundle: decoder/EX/memory inputs and IF/ID hazard outputs.
// The controller takes the slave side; whoever models the pipeline takes master.
interface decode_hazard_controller_if;
   logic        id_valid;
   logic [25:0] id_control_word;
   logic [2:0]  id_branch_sel;
   logic        ex_redirect;
   logic        mem_busy;
   logic        if_stall;
   logic        id_stall;
   logic        if_flush;
   logic        id_flush;
   logic        issue_valid;
   logic [1:0]  ctrl_state;
   logic [31:0] load_use_stalls;

   modport master (
      output id_valid, id_control_word, id_branch_sel,
      output ex_redirect, mem_busy,
      input  if_stall, id_stall, if_flush, id_flush,
      input  issue_valid, ctrl_state, load_use_stalls
   );

   modport slave (
      input  id_valid, id_control_word, id_branch_sel,
      input  ex_redirect, mem_busy,
      output if_stall, id_stall, if_flush, id_flush,
      output issue_valid, ctrl_state, load_use_stalls
   );
endinterface

// File: rtl/decode_hazard_controller.sv
// Decode-stage sequencer: load-use scoreboard, redirect flush timing and
// memory-busy freeze, driving IF/ID stall/flush and ID->EX issue.
module decode_hazard_controller #(
   parameter int NUM_REGS     = 32,
   parameter int LOAD_LAT     = 1,
   parameter int FLUSH_CYCLES = 2
) (
   input logic                       clk,
   input logic                       reset,
   decode_hazard_controller_if.slave bus
);
   localparam int SBW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
   localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   state_e           resume_q, resume_d;
   state_e           eff_state;
   logic [FCW-1:0]   fcnt_q, fcnt_d;
   logic [31:0]      stalls_q, stalls_d;
   logic [SBW-1:0]   sb_q [NUM_REGS];
   logic [SBW-1:0]   sb_d [NUM_REGS];

   logic [4:0]       d_addr;
   logic [4:0]       b_sel;
   logic [4:0]       a_sel;
   logic             we;
   logic             is_load;
   logic             use_imm;
   logic             rs1_used;
   logic             rs2_used;
   logic             hazard;

   logic             sel_mem;
   logic             sel_flush;
   logic             sel_haz;
   logic             dec_en;

   logic             if_stall_c;
   logic             id_stall_c;
   logic             if_flush_c;
   logic             id_flush_c;
   logic             issue_c;

   always_comb begin
      d_addr   = bus.id_control_word[25:21];
      b_sel    = bus.id_control_word[20:16];
      a_sel    = bus.id_control_word[15:11];
      we       = bus.id_control_word[6];
      is_load  = bus.id_control_word[4];
      use_imm  = bus.id_control_word[3];
      rs1_used = a_sel != 5'd0;
      rs2_used = (!use_imm || !we) && b_sel != 5'd0;
      hazard   = bus.id_valid &&
                 ((rs1_used && sb_q[a_sel] != '0) ||
                  (rs2_used && sb_q[b_sel] != '0));
   end

   // MEM_WAIT resumes whatever the interrupted state was doing.
   always_comb begin
      eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;
      sel_mem   = bus.mem_busy;
      sel_flush = !bus.mem_busy &&
                  (bus.ex_redirect || eff_state == FLUSH);
      sel_haz   = !bus.mem_busy && !sel_flush && hazard;
   end

   always_comb begin
      state_d    = state_q;
      resume_d   = resume_q;
      fcnt_d     = fcnt_q;
      stalls_d   = stalls_q;
      dec_en     = 1'b0;
      if_stall_c = 1'b0;
      id_stall_c = 1'b0;
      if_flush_c = 1'b0;
      id_flush_c = 1'b0;
      issue_c    = 1'b0;
      unique case (1'b1)
         sel_mem: begin
            if_stall_c = 1'b1;
            id_stall_c = 1'b1;
            resume_d   = eff_state;
            state_d    = MEM_WAIT;
         end
         sel_flush: begin
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
            dec_en     = 1'b1;
            if (bus.ex_redirect) begin
               fcnt_d = FCW'(FLUSH_CYCLES - 1);
            end else begin
               fcnt_d = fcnt_q - 1'b1;
            end
            state_d = (fcnt_d != '0) ? FLUSH : RUN;
         end
         sel_haz: begin
            if_stall_c = 1'b1;
            id_stall_c = 1'b1;
            id_flush_c = 1'b1;
            dec_en     = 1'b1;
            stalls_d   = stalls_q + 32'd1;
            state_d    = LOAD_STALL;
         end
         default: begin
            issue_c = bus.id_valid;
            dec_en  = 1'b1;
            state_d = RUN;
         end
      endcase
   end

   // Decrement first so a fresh load on the same register wins.
   always_comb begin
      sb_d = sb_q;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (dec_en && sb_q[i] != '0) begin
            sb_d[i] = sb_q[i] - 1'b1;
         end
      end
      if (issue_c && is_load && d_addr != 5'd0) begin
         sb_d[d_addr] = SBW'(LOAD_LAT);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RUN;
         resume_q <= RUN;
         fcnt_q   <= '0;
         stalls_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         fcnt_q   <= fcnt_d;
         stalls_q <= stalls_d;
         sb_q     <= sb_d;
      end
   end

   // Outputs are forced quiet while reset is held.
   assign bus.if_stall        = reset & if_stall_c;
   assign bus.id_stall        = reset & id_stall_c;
   assign bus.if_flush        = reset & if_flush_c;
   assign bus.id_flush        = reset & id_flush_c;
   assign bus.issue_valid     = reset & issue_c;
   assign bus.ctrl_state      = state_q;
   assign bus.load_use_stalls = stalls_q;

   a_no_branch_issue_in_flush: assert property (
      @(posedge clk) disable iff (!reset)
      (sel_flush && bus.id_valid && bus.id_branch_sel != 3'd0)
         |-> !bus.issue_valid
   );

   a_known_control_word: assert property (
      @(posedge clk) disable iff (!reset)
      bus.id_valid |-> !$isunknown(bus.id_control_word)
   );
endmodule

// File: tb/tb_decode_hazard_controller.sv
// Directed bench for decode_hazard_controller: load-use stalls, redirect
// flushes, memory-busy freeze and async reset, with hand-computed outputs.
module tb_decode_hazard_controller;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   decode_hazard_controller_if bus ();

   decode_hazard_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [25:0] cw(logic [4:0] d, logic [4:0] b,
                                      logic [4:0] a, logic w,
                                      logic ld, logic imm);
      return {d, b, a, 4'd0, w, 1'b0, ld, imm, 3'b010};
   endfunction

   // outs = {if_stall, id_stall, if_flush, id_flush, issue_valid}
   task automatic expect_outs(string tag, logic [4:0] outs,
                              logic [1:0] st, logic [31:0] n);
      check({tag, "/ctl"}, {27'd0, bus.if_stall, bus.id_stall,
            bus.if_flush, bus.id_flush, bus.issue_valid}, {27'd0, outs});
      check({tag, "/st"}, {30'd0, bus.ctrl_state}, {30'd0, st});
      check({tag, "/cnt"}, bus.load_use_stalls, n);
   endtask

   task automatic drive(logic v, logic [25:0] w, logic [2:0] br,
                        logic rd, logic mb);
      bus.id_valid        = v;
      bus.id_control_word = w;
      bus.id_branch_sel   = br;
      bus.ex_redirect     = rd;
      bus.mem_busy        = mb;
   endtask

   task automatic step(string tag, logic v, logic [25:0] w,
                       logic [2:0] br, logic rd, logic mb,
                       logic [4:0] outs, logic [1:0] st,
                       logic [31:0] n);
      drive(v, w, br, rd, mb);
      @(negedge clk);
      expect_outs(tag, outs, st, n);
      @(posedge clk);
      #1;
   endtask

   logic [25:0] lw_x5, add_x6, addi_x6, sw_x5, lw_x0, add_x2;

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      lw_x5   = cw(5'd5, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1);
      add_x6  = cw(5'd6, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      addi_x6 = cw(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
      sw_x5   = cw(5'd0, 5'd5, 5'd2, 1'b0, 1'b0, 1'b1);
      lw_x0   = cw(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1);
      add_x2  = cw(5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);

      reset = 1'b0;
      drive(1'b1, add_x6, 3'd0, 1'b1, 1'b0);
      @(negedge clk);
      expect_outs("rst", 5'b00000, 2'd0, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      step("lw1",   1, lw_x5,   0, 0, 0, 5'b00001, 2'd0, 0);
      step("use1",  1, add_x6,  0, 0, 0, 5'b11010, 2'd0, 0);
      step("iss1",  1, add_x6,  0, 0, 0, 5'b00001, 2'd1, 1);

      step("lw2",   1, lw_x5,   0, 0, 0, 5'b00001, 2'd0, 1);
      step("addi",  1, addi_x6, 0, 0, 0, 5'b00001, 2'd0, 1);
      step("lw3",   1, lw_x5,   0, 0, 0, 5'b00001, 2'd0, 1);
      step("sw",    1, sw_x5,   0, 0, 0, 5'b11010, 2'd0, 1);
      step("swiss", 1, sw_x5,   0, 0, 0, 5'b00001, 2'd1, 2);

      step("lwx0",  1, lw_x0,   0, 0, 0, 5'b00001, 2'd0, 2);
      step("addx0", 1, add_x2,  0, 0, 0, 5'b00001, 2'd0, 2);

      step("rd1",   1, add_x6,  0, 1, 0, 5'b00110, 2'd0, 2);
      step("fl1",   1, add_x6,  3, 0, 0, 5'b00110, 2'd2, 2);
      step("fl1e",  1, add_x6,  0, 0, 0, 5'b00001, 2'd0, 2);

      step("rd2",   1, add_x6,  0, 1, 0, 5'b00110, 2'd0, 2);
      step("rd2b",  1, add_x6,  0, 1, 0, 5'b00110, 2'd2, 2);
      step("fl2",   1, add_x6,  3, 0, 0, 5'b00110, 2'd2, 2);
      step("fl2e",  1, add_x6,  0, 0, 0, 5'b00001, 2'd0, 2);

      step("lw4",   1, lw_x5,   0, 0, 0, 5'b00001, 2'd0, 2);
      step("mb0",   1, add_x6,  0, 1, 1, 5'b11000, 2'd0, 2);
      step("mb1",   1, add_x6,  0, 0, 1, 5'b11000, 2'd3, 2);
      step("mb2",   1, add_x6,  0, 1, 1, 5'b11000, 2'd3, 2);
      step("mb3",   1, add_x6,  0, 0, 1, 5'b11000, 2'd3, 2);
      step("mbrel", 1, add_x6,  0, 0, 0, 5'b11010, 2'd3, 2);
      step("mbiss", 1, add_x6,  0, 0, 0, 5'b00001, 2'd1, 3);

      step("rd3",   1, add_x6,  0, 1, 0, 5'b00110, 2'd0, 3);
      drive(1'b1, add_x6, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      expect_outs("fl3", 5'b00110, 2'd2, 3);
      #2;
      reset = 1'b0;
      #1;
      expect_outs("rstfl", 5'b00000, 2'd0, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step("post1", 1, add_x6,  0, 0, 0, 5'b00001, 2'd0, 0);

      step("lw5",   1, lw_x5,   0, 0, 0, 5'b00001, 2'd0, 0);
      drive(1'b1, add_x6, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      expect_outs("use5", 5'b11010, 2'd0, 0);
      #2;
      reset = 1'b0;
      #1;
      expect_outs("rstls", 5'b00000, 2'd0, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step("post2", 1, add_x6,  0, 0, 0, 5'b00001, 2'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/decode_hazard_controller.md
Name: decode_hazard_controller

Overview:
- Sequences the decode stage. Consumes the decoder's 26-bit control word and branch select for the instruction held in ID.
- Tracks in-flight loads in a per-register countdown scoreboard and inserts load-use bubbles.
- Sequences multi-cycle front-end flushes on taken branches/jumps and freezes the pipeline while data memory is busy.
- Sits between the decoder and the ID/EX pipeline register and drives IF/ID stall and flush controls.

Parameters:
- NUM_REGS, 32: architectural registers; x0 is never tracked.
- LOAD_LAT, 1: cycles after issue before a load result can be forwarded to a consumer in ID.
- FLUSH_CYCLES, 2: front-end bubbles inserted after a taken redirect.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_control_word  in  26  decoder control word. Fields: [25:21] d_addr, [20:16] b_select, [15:11] a_select, [10:7] function_select, [6] we, [5] save_pc, [4] load, [3] use_immediate, [2:0] mem_width_sel.
- id_branch_sel  in  3  decoder branch select; nonzero means a control-flow instruction.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- if_stall  out  1  hold PC and IF/ID.
- id_stall  out  1  hold ID contents.
- if_flush  out  1  squash IF/ID.
- id_flush  out  1  load a bubble into ID/EX.
- issue_valid  out  1  the ID instruction transfers to EX this cycle.
- ctrl_state  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 FLUSH, 3 MEM_WAIT.
- load_use_stalls  out  32  count of load-use bubble cycles; wraps.

Behaviour:
- Reset (async, reset=0):
  - state RUN, all scoreboard counters 0, flush counter 0, load_use_stalls 0.
  - All stall/flush outputs 0; issue_valid 0.
- Register usage decode:
  - rs1 used = a_select!=0.
  - rs2 used = (use_immediate==0 | we==0) & b_select!=0. This covers R, B and S types.
- Hazard condition: id_valid & ((rs1 used & sb[a_select]!=0) | (rs2 used & sb[b_select]!=0)).
- Priority each cycle: mem_busy > ex_redirect or active FLUSH > hazard > normal issue.
- MEM_WAIT (mem_busy=1):
  - if_stall=id_stall=1; id_flush=if_flush=0; issue_valid=0.
  - Scoreboard and flush counter frozen; ex_redirect ignored.
  - Return to the previous state's evaluation the cycle mem_busy drops.
- Redirect (ex_redirect=1, mem_busy=0):
  - Enter FLUSH with flush counter = FLUSH_CYCLES-1.
  - if_flush=id_flush=1 in this cycle and every FLUSH cycle; issue_valid=0.
  - Leave to RUN when counter reaches 0. A new ex_redirect in FLUSH reloads the counter.
  - Overrides any hazard.
- LOAD_STALL (hazard, no redirect, mem_busy=0):
  - if_stall=id_stall=1, id_flush=1 (bubble), issue_valid=0.
  - load_use_stalls += 1.
  - Return to RUN when the hazard clears; the instruction issues that same cycle.
- RUN: issue_valid=id_valid; all stall/flush outputs 0.
- Scoreboard:
  - Each non-frozen cycle, every nonzero counter decrements by 1.
  - On issue of an instruction with load=1 and d_addr!=0, sb[d_addr] is set to LOAD_LAT; load wins over decrement on the same register.
  - Counter width is clog2(LOAD_LAT+1). Writes to x0 are ignored.
- Flush-scoreboard interaction: the load that was issued before the redirect stays tracked; bubbles never set entries.
- Branch interaction: id_branch_sel!=0 has no effect on stall/issue; it is used only for assertions (a branch in ID must not issue while FLUSH is active).
- Reset asserted mid-FLUSH or mid-stall returns immediately to RUN with all state cleared.
- All outputs are combinational from registered state plus current inputs; there is no added latency.

Test Plan:
- lw x5,0(x1) issues, then add x6,x5,x2 in ID next cycle -> one LOAD_STALL cycle (if_stall=id_stall=id_flush=1, load_use_stalls=1); add issues the following cycle.
- lw x5 followed by addi x6,x0,5 (rs1=x0) -> no stall. Then sw x5,0(x2) (rs2=x5, use_immediate=1, we=0) one cycle after the load -> stall.
- ex_redirect pulse with FLUSH_CYCLES=2 -> if_flush=id_flush=1 for exactly 2 cycles, issue_valid=0, ctrl_state=2 then 0. A second redirect in cycle 2 extends the flush to 3 cycles total.
- mem_busy held 4 cycles while sb[x5]=1 and add x6,x5 in ID -> ctrl_state=3, counters frozen. After release: 1 stall cycle, then issue.
- lw x0,0(x1) then add x2,x0,x0 -> no stall; load_use_stalls stays 0.
- reset low during FLUSH and LOAD_STALL -> all outputs 0 immediately. After reset release with id_valid=1 -> issue_valid=1 the first cycle.
